// File: rtl/rr_demux_arbiter.sv
// Round-robin arbiter that shares one 3-to-8 select/enable demux path among
// eight requesters. It registers the owner index, the path enable and the
// matching one-hot grant. Each grant has a bounded hold time, and at least
// one idle turnaround cycle separates two grants.
module rr_demux_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] REQ,
  input  logic       DONE,
  output logic [2:0] GNT_S,
  output logic       GNT_EN,
  output logic [7:0] GNT,
  output logic       BUSY
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] last;
  logic [2:0] last_next;
  logic [7:0] hcnt;
  logic [7:0] hcnt_next;
  logic [2:0] sel_next;
  logic       en_next;
  logic [7:0] gnt_next;
  logic       grant_end;
  logic       hold_expired;
  logic [2:0] winner;

  // First set request bit searching upward from last+1, wrapping 7 -> 0.
  // The most recent owner is therefore visited last.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] prev);
    logic [2:0] idx;
    logic       found;
    rr_pick = prev;
    found   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = prev + 3'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner       = rr_pick(REQ, last);
  assign hold_expired = (MAX_HOLD != 0) && (hcnt == 8'(MAX_HOLD));
  assign grant_end    = DONE || !REQ[GNT_S] || hold_expired;
  assign BUSY         = GNT_EN;

  // State and registered outputs; reset drops the grant with no clock needed
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      last   <= 3'd7;
      hcnt   <= 8'd0;
      GNT_S  <= 3'd0;
      GNT_EN <= 1'b0;
      GNT    <= 8'h00;
    end else begin
      state  <= state_next;
      last   <= last_next;
      hcnt   <= hcnt_next;
      GNT_S  <= sel_next;
      GNT_EN <= en_next;
      GNT    <= gnt_next;
    end
  end

  // Next-state: leave IDLE on any request, leave GRANT on any end condition
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (REQ != 8'h00) state_next = GRANT;
      GRANT:   if (grant_end)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, the hold counter and the last owner
  always_comb begin
    sel_next  = GNT_S;
    en_next   = 1'b0;
    last_next = last;
    hcnt_next = 8'd0;
    case (state)
      IDLE: begin
        if (REQ != 8'h00) begin
          sel_next  = winner;
          en_next   = 1'b1;
          last_next = winner;
          hcnt_next = 8'd1;
        end
      end
      GRANT: begin
        if (!grant_end) begin
          en_next   = 1'b1;
          hcnt_next = (hcnt == 8'hFF) ? hcnt : hcnt + 8'd1;
        end
      end
      default: begin
        en_next = 1'b0;
      end
    endcase
    gnt_next = en_next ? (8'(1) << sel_next) : 8'h00;
  end

  // Grant vector must always agree with the select/enable decoder view
  a_onehot : assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(GNT));
  a_decode : assert property (@(posedge CLK) disable iff (!RST_N)
                              GNT == (GNT_EN ? (8'(1) << GNT_S) : 8'h00));
  a_busy   : assert property (@(posedge CLK) disable iff (!RST_N) BUSY == GNT_EN);

endmodule
